// File: rtl/grant_xfer_ctrl.sv
// rtl/grant_xfer_ctrl.sv - grant-driven single-payload transfer controller (IDLE/WAIT/SEND)
// Optional macro GRANT_XFER_ONEHOT_CHK_EN: sticky err when the WAIT-state grant hit is not one-hot.
module grant_xfer_ctrl #(
  parameter int REQUEST_LINES = 4,
  parameter int DATA_W        = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [REQUEST_LINES-1:0]          req_valid,
  input  logic [REQUEST_LINES*DATA_W-1:0]   req_data,
  output logic [REQUEST_LINES-1:0]          req_ack,
  output logic [REQUEST_LINES-1:0]          arb_req,
  output logic                              arb_en,
  input  logic [REQUEST_LINES-1:0]          arb_grant,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_W-1:0]                 out_data,
  output logic [$clog2(REQUEST_LINES)-1:0]  out_src,
  output logic                              err
);

  localparam int SRC_W = $clog2(REQUEST_LINES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic [SRC_W-1:0]         src_q, src_d;
  logic                     run_q;
  logic [REQUEST_LINES-1:0] hit;
  logic                     hit_any;
  logic [SRC_W-1:0]         sel;

  assign arb_req   = req_valid;
  assign hit       = arb_grant & req_valid;
  assign hit_any   = |hit;
  assign out_valid = (state_q == ST_SEND);
  assign out_data  = data_q;
  assign out_src   = src_q;

  // Lowest set index wins, so a malformed multi-bit grant still picks one line.
  always_comb begin
    sel = '0;
    for (int i = REQUEST_LINES - 1; i >= 0; i--) begin
      if (hit[i]) sel = SRC_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    arb_en  = 1'b0;
    req_ack = '0;
    case (state_q)
      ST_IDLE: begin
        // run_q holds off the first enable until a clock edge has passed since reset release.
        if (run_q && (|req_valid)) begin
          arb_en  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (hit_any) begin
          req_ack[sel] = 1'b1;
          data_d       = req_data[sel*DATA_W +: DATA_W];
          src_d        = sel;
          state_d      = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      src_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      run_q   <= 1'b1;
    end
  end

`ifdef GRANT_XFER_ONEHOT_CHK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((state_q == ST_WAIT) && hit_any && ((hit & (hit - 1'b1)) != '0)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_grant_xfer_ctrl.sv
// tb/tb_grant_xfer_ctrl.sv - self-checking bench for grant_xfer_ctrl
module tb_grant_xfer_ctrl;

  localparam int N  = 4;
  localparam int DW = 32;

`ifdef GRANT_XFER_ONEHOT_CHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ack, arb_req, arb_grant, next_grant;
  logic [N*DW-1:0] req_data;
  logic          arb_en, out_valid, out_ready, err;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;

  int n_vec = 0;
  int n_err = 0;

  grant_xfer_ctrl #(.REQUEST_LINES(N), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .arb_req(arb_req), .arb_en(arb_en), .arb_grant(arb_grant),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .err(err)
  );

  always #5 clk = ~clk;

  // Arbiter stand-in: registered grant, updated only on arb_en, held otherwise.
  always @(posedge clk or posedge rst) begin
    if (rst) arb_grant <= '0;
    else if (arb_en) arb_grant <= next_grant;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b0001; req_data = '0; out_ready = 1'b0; next_grant = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0h want 0", out_valid); end
    n_vec++; if (req_ack !== 4'b0) begin n_err++; $display("FAIL rst_req_ack: got %0h want 0", req_ack); end
    n_vec++; if (arb_en !== 1'b0) begin n_err++; $display("FAIL rst_arb_en: got %0h want 0", arb_en); end
    n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rst_out_data: got %0h want 0", out_data); end
    n_vec++; if (out_src !== 2'd0) begin n_err++; $display("FAIL rst_out_src: got %0h want 0", out_src); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %0h want 0", err); end
    n_vec++; if (arb_req !== 4'b0001) begin n_err++; $display("FAIL rst_arb_req: got %0h want 1", arb_req); end
    rst = 1'b0;
    #1;
    n_vec++; if (arb_en !== 1'b0) begin n_err++; $display("FAIL rel_arb_en_early: got %0h want 0", arb_en); end
    tick();
    n_vec++; if (arb_en !== 1'b1) begin n_err++; $display("FAIL rel_arb_en_after_edge: got %0h want 1", arb_en); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    req_valid = 4'b0100; set_line(2, 32'hA5A5A5A5); out_ready = 1'b1; next_grant = 4'b0100;
    @(negedge clk);
    n_vec++; if (arb_en !== 1'b1) begin n_err++; $display("FAIL single_en_c0: got %0h want 1", arb_en); end
    n_vec++; if (arb_req !== 4'b0100) begin n_err++; $display("FAIL single_arb_req: got %0h want 4", arb_req); end
    n_vec++; if (req_ack !== 4'b0) begin n_err++; $display("FAIL single_ack_c0: got %0h want 0", req_ack); end
    tick();
    @(negedge clk);
    n_vec++; if (req_ack !== 4'b0100) begin n_err++; $display("FAIL single_ack_c1: got %0h want 4", req_ack); end
    n_vec++; if (arb_en !== 1'b0) begin n_err++; $display("FAIL single_en_c1: got %0h want 0", arb_en); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_ov_c1: got %0h want 0", out_valid); end
    tick(); req_valid = '0;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_ov_c2: got %0h want 1", out_valid); end
    n_vec++; if (out_data !== 32'hA5A5A5A5) begin n_err++; $display("FAIL single_data_c2: got %0h want a5a5a5a5", out_data); end
    n_vec++; if (out_src !== 2'd2) begin n_err++; $display("FAIL single_src_c2: got %0h want 2", out_src); end
    n_vec++; if (req_ack !== 4'b0) begin n_err++; $display("FAIL single_ack_c2: got %0h want 0", req_ack); end
    tick(); req_valid = 4'b0001;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_ov_c3: got %0h want 0", out_valid); end
    n_vec++; if (arb_en !== 1'b1) begin n_err++; $display("FAIL single_idle_c3: got %0h want 1", arb_en); end
    tick(); req_valid = '0;
    @(negedge clk);
    n_vec++; if (req_ack !== 4'b0) begin n_err++; $display("FAIL stale_grant_ack: got %0h want 0", req_ack); end
    tick();
  endtask

  task automatic test_backpressure();
    int acks = 0;
    req_valid = 4'b0100; set_line(2, 32'hA5A5A5A5); out_ready = 1'b0; next_grant = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_ack != '0) acks++;
      if (c >= 2 && c <= 7) begin
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_ov c%0d: got %0h want 1", c, out_valid); end
        n_vec++; if (out_data !== 32'hA5A5A5A5) begin n_err++; $display("FAIL bp_data c%0d: got %0h want a5a5a5a5", c, out_data); end
        n_vec++; if (out_src !== 2'd2) begin n_err++; $display("FAIL bp_src c%0d: got %0h want 2", c, out_src); end
      end
      if (c == 8) begin
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_ov_end: got %0h want 0", out_valid); end
      end
      tick();
      if (c == 1) begin req_valid = '0; set_line(2, $urandom); end
      if (c == 6) out_ready = 1'b1;
    end
    n_vec++; if (acks !== 1) begin n_err++; $display("FAIL bp_ack_count: got %0d want 1", acks); end
  endtask

  task automatic test_back_to_back();
    int k = 0, nout = 0, last = -100;
    logic [N-1:0] acked, e;
    req_valid = 4'b1111; out_ready = 1'b1; next_grant = 4'b0001;
    for (int i = 0; i < N; i++) set_line(i, 32'hB0B00000 + DW'(i));
    for (int c = 0; c < 40 && nout < 4; c++) begin
      @(negedge clk);
      acked = req_ack;
      if (req_ack != '0) begin
        e = 4'b0001 << k;
        n_vec++; if (req_ack !== e) begin n_err++; $display("FAIL b2b_ack: got %0h want %0h", req_ack, e); end
        k++;
        next_grant = 4'b0001 << k;
      end
      if (out_valid) begin
        n_vec++; if (out_src !== 2'(nout)) begin n_err++; $display("FAIL b2b_src: got %0d want %0d", out_src, nout); end
        n_vec++; if (out_data !== 32'hB0B00000 + DW'(nout)) begin n_err++; $display("FAIL b2b_data: got %0h want %0h", out_data, 32'hB0B00000 + DW'(nout)); end
        n_vec++; if (c - last < 3) begin n_err++; $display("FAIL b2b_gap: got %0d want >=3", c - last); end
        last = c;
        nout++;
      end
      tick();
      req_valid = req_valid & ~acked;
    end
    n_vec++; if (nout !== 4) begin n_err++; $display("FAIL b2b_xfers: got %0d want 4", nout); end
    n_vec++; if (k !== 4) begin n_err++; $display("FAIL b2b_acks: got %0d want 4", k); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_withdraw();
    req_valid = 4'b0010; next_grant = 4'b0010; out_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (arb_en !== 1'b1) begin n_err++; $display("FAIL wd_en: got %0h want 1", arb_en); end
    tick(); req_valid = '0;
    @(negedge clk);
    n_vec++; if (req_ack !== 4'b0) begin n_err++; $display("FAIL wd_ack: got %0h want 0", req_ack); end
    tick(); req_valid = 4'b0001;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL wd_ov: got %0h want 0", out_valid); end
    n_vec++; if (arb_en !== 1'b1) begin n_err++; $display("FAIL wd_idle: got %0h want 1", arb_en); end
    tick(); req_valid = '0;
    @(negedge clk);
    n_vec++; if (req_ack !== 4'b0) begin n_err++; $display("FAIL wd_probe_ack: got %0h want 0", req_ack); end
    tick();
  endtask

  task automatic test_bad_grant();
    req_valid = 4'b0110; set_line(1, 32'h11111111); set_line(2, 32'h22222222);
    next_grant = 4'b0110; out_ready = 1'b1;
    tick();
    @(negedge clk);
    n_vec++; if (req_ack !== 4'b0010) begin n_err++; $display("FAIL bad_ack: got %0h want 2", req_ack); end
    tick(); req_valid = 4'b0100; next_grant = 4'b0100;
    @(negedge clk);
    n_vec++; if (out_src !== 2'd1) begin n_err++; $display("FAIL bad_src: got %0h want 1", out_src); end
    n_vec++; if (out_data !== 32'h11111111) begin n_err++; $display("FAIL bad_data: got %0h want 11111111", out_data); end
    n_vec++; if (err !== CHK) begin n_err++; $display("FAIL bad_err: got %0h want %0h", err, CHK); end
    tick(); tick();
    @(negedge clk);
    n_vec++; if (req_ack !== 4'b0100) begin n_err++; $display("FAIL bad_next_ack: got %0h want 4", req_ack); end
    n_vec++; if (err !== CHK) begin n_err++; $display("FAIL bad_err_sticky: got %0h want %0h", err, CHK); end
    tick(); req_valid = '0;
    tick();
    @(negedge clk);
    n_vec++; if (err !== CHK) begin n_err++; $display("FAIL bad_err_idle: got %0h want %0h", err, CHK); end
    tick();
  endtask

  task automatic test_reset_mid_send();
    req_valid = 4'b1000; set_line(3, 32'hDEADBEEF); next_grant = 4'b1000; out_ready = 1'b0;
    tick();
    @(negedge clk);
    n_vec++; if (req_ack !== 4'b1000) begin n_err++; $display("FAIL rms_ack: got %0h want 8", req_ack); end
    tick(); req_valid = '0;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rms_ov_pre: got %0h want 1", out_valid); end
    #1 rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rms_ov: got %0h want 0", out_valid); end
    n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rms_data: got %0h want 0", out_data); end
    n_vec++; if (out_src !== 2'd0) begin n_err++; $display("FAIL rms_src: got %0h want 0", out_src); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rms_err: got %0h want 0", err); end
    #1 rst = 1'b0; req_valid = 4'b0001; next_grant = '0;
    #1;
    n_vec++; if (arb_en !== 1'b0) begin n_err++; $display("FAIL rms_en_early: got %0h want 0", arb_en); end
    tick();
    n_vec++; if (arb_en !== 1'b1) begin n_err++; $display("FAIL rms_idle: got %0h want 1", arb_en); end
    tick(); req_valid = '0;
    @(negedge clk);
    n_vec++; if (req_ack !== 4'b0) begin n_err++; $display("FAIL rms_ack_after: got %0h want 0", req_ack); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int ph = 0;
    logic [DW-1:0] md = '0;
    logic [1:0] ms = '0;
    logic me = 1'b0;
    logic [N-1:0] drop = '0, hit, e_ack;
    logic e_en;
    int low;
    rst = 1'b1; req_valid = '0; next_grant = '0;
    @(negedge clk); rst = 1'b0;
    tick();
    for (int c = 0; c < 400; c++) begin
      req_valid = req_valid & ~drop;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          set_line(i, $urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) next_grant = N'($urandom);
      else next_grant = 4'b0001 << $urandom_range(0, N - 1);
      hit = arb_grant & req_valid;
      low = lowest(hit);
      e_en = (ph == 0) && (req_valid != '0);
      e_ack = (ph == 1 && hit != '0) ? (4'b0001 << low) : 4'b0000;
      @(negedge clk);
      n_vec++; if (arb_en !== e_en) begin n_err++; $display("FAIL rnd_en c%0d: got %0h want %0h", c, arb_en, e_en); end
      n_vec++; if (req_ack !== e_ack) begin n_err++; $display("FAIL rnd_ack c%0d: got %0h want %0h", c, req_ack, e_ack); end
      n_vec++; if (out_valid !== (ph == 2)) begin n_err++; $display("FAIL rnd_ov c%0d: got %0h want %0h", c, out_valid, ph == 2); end
      n_vec++; if (out_data !== md) begin n_err++; $display("FAIL rnd_data c%0d: got %0h want %0h", c, out_data, md); end
      n_vec++; if (out_src !== ms) begin n_err++; $display("FAIL rnd_src c%0d: got %0h want %0h", c, out_src, ms); end
      n_vec++; if (err !== me) begin n_err++; $display("FAIL rnd_err c%0d: got %0h want %0h", c, err, me); end
      case (ph)
        0: ph = (req_valid != '0) ? 1 : 0;
        1: begin
          if (hit != '0) begin
            md = req_data[low*DW +: DW];
            ms = 2'(low);
            if (CHK && $countones(hit) > 1) me = 1'b1;
            ph = 2;
          end else begin
            ph = 0;
          end
        end
        default: if (out_ready) ph = 0;
      endcase
      drop = e_ack;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_withdraw();
    test_bad_grant();
    test_reset_mid_send();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
